coax_fifo: RTL
==============

// Module: coax_fifo
// PURPOSE
//  Parametrised synchronous FIFO, the successor of the fixed 12-bit x 32 coax word buffer.
//  Buffers coax words between the receive or transmit datapath and the host-side logic.
//  Adds the following to the fixed buffer:
//   - full power-of-two capacity
//   - almost-full and almost-empty thresholds
//   - a sticky overflow flag and a sticky underflow flag
//   - a saturating drop counter
//   - a synchronous flush
//  Keeps the runtime choice of discarding new or old data when full.
// PARAMETERS
//  WIDTH      12  data word width in bits
//  ADDR_W     5   log2 depth; DEPTH = 2**ADDR_W entries, all usable
//  AF_LEVEL   24  almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL   4   almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clk           in   1         clock; all logic on rising edge
//  reset         in   1         synchronous, active-high
//  mode          in   1         0 = drop new word when full; 1 = overwrite oldest when full
//  flush         in   1         synchronous empty request; storage contents not cleared
//  clr_status    in   1         clears overflow, underflow and drop_count
//  wen           in   1         write strobe
//  wdata         in   WIDTH     write data
//  ren           in   1         read/pop strobe
//  rdata         out  WIDTH     head word, first-word-fall-through; don't-care when valid=0
//  valid         out  1         FIFO non-empty
//  full          out  1         count == DEPTH
//  almost_full   out  1         count >= AF_LEVEL
//  almost_empty  out  1         count <= AE_LEVEL
//  count         out  ADDR_W+1  occupancy, 0..DEPTH
//  overflow      out  1         sticky; set on any write that drops data
//  underflow     out  1         sticky; set on ren while empty
//  drop_count    out  16        saturating count of dropped words (saturates at 16'hFFFF)
// BEHAVIOUR
//  - Priority order: reset > flush > normal operation. All flags are registered or derived from registered pointers.
//  - Reset values:
//     - count=0, valid=0, full=0, almost_full=0, almost_empty=1
//     - overflow=0, underflow=0, drop_count=0
//     - memory is not reset
//  - Pointers are wr_ptr and rd_ptr, each ADDR_W+1 bits.
//     - count = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
//     - Wrap-around is the natural overflow of the pointer width.
//  - rdata = mem[rd_ptr[ADDR_W-1:0]], asynchronous read; zero latency.
//  - A write is visible on rdata and valid the cycle after wen is sampled.
//  - Normal cycle, where W = wen and R = ren:
//     - not full, not empty: W stores at wr_ptr and increments it; R increments rd_ptr; both may happen together.
//     - empty, R=1: the pop is ignored and underflow sets.
//     - empty, W=1 and R=1: the write is accepted; the read is ignored and underflow sets.
//     - full, W=1 and R=1: pop and push both proceed; count stays DEPTH; no drop.
//     - full, W=1, R=0, mode=0: the write is discarded; drop_count+1; overflow sets.
//     - full, W=1, R=0, mode=1: wdata is written at wr_ptr and both pointers increment.
//       The oldest word is lost; drop_count+1; overflow sets; count stays DEPTH.
//     - full, W=0, R=1: normal pop.
//  - flush: both pointers go to 0 next cycle. wen/ren in that cycle are ignored and not counted as drops.
//    Status flags are unaffected by flush.
//  - clr_status: clears overflow, underflow and drop_count next cycle.
//    If a drop or underflow event occurs in the same cycle, the event wins: flag=1, drop_count=1.
//  - drop_count holds at 16'hFFFF once reached; overflow stays 1.
//  - mode may change on any cycle and takes effect on that cycle's write.
//  - reset mid-stream: everything returns to reset values next cycle; pending strobes are ignored.
// STRUCTURE
//  - Package coax_fifo_pkg holds:
//     - MODE_DROP_NEW = 1'b0
//     - MODE_DROP_OLD = 1'b1
//     - DROP_CNT_W = 16
//     - a function to compute threshold compare widths
//  - Sub-module coax_fifo_ram: simple dual-port memory, WIDTH x 2**ADDR_W.
//     - synchronous write, asynchronous read, no reset
//  - Top level holds pointers, flag logic and counters.
// TESTING (defaults WIDTH=12, ADDR_W=5, AF=24, AE=4)
//  1. Reset, then write 0x001..0x020 (32 words) with no reads.
//     -> full=1, count=32, almost_full=1, overflow=0; read back returns 0x001..0x020 in order; valid=0 after the last pop.
//  2. Full with mode=0, write 0xABC.
//     -> count=32, drop_count=1, overflow=1, head still 0x001, 0xABC never read.
//  3. Full with mode=1, write 0xABC.
//     -> drop_count=1, rdata=0x002 next cycle, the last word popped is 0xABC.
//  4. Empty, assert wen=1 (0x555) and ren=1 together.
//     -> count=1, rdata=0x555, underflow=1.
//     Then clr_status together with another empty ren -> underflow stays 1.
//  5. Full, assert wen and ren together for 100 cycles.
//     -> count stays 32, drop_count=0, FIFO ordering preserved across pointer wrap.
//  6. Fill 10 words, then flush together with wen.
//     -> count=0, valid=0, almost_empty=1, drop_count unchanged.
//     A subsequent 2^16+5 mode-0 drops -> drop_count=0xFFFF.

Source files
------------

// File: rtl/coax_fifo_pkg.sv
// Shared constants and helpers for the coax word FIFO.
package coax_fifo_pkg;

    typedef enum logic {
        MODE_DROP_NEW = 1'b0,
        MODE_DROP_OLD = 1'b1
    } mode_e;

    localparam int unsigned DROP_CNT_W = 16;

    // Occupancy and thresholds need one bit more than the address to represent DEPTH itself.
    function automatic int unsigned cnt_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/coax_fifo_if.sv
// Host-side control, data and status bundle of the coax word FIFO.
interface coax_fifo_if #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned ADDR_W = 5
);
    import coax_fifo_pkg::*;

    logic                  mode;
    logic                  flush;
    logic                  clr_status;
    logic                  wen;
    logic [WIDTH-1:0]      wdata;
    logic                  ren;
    logic [WIDTH-1:0]      rdata;
    logic                  valid;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_W:0]       count;
    logic                  overflow;
    logic                  underflow;
    logic [DROP_CNT_W-1:0] drop_count;

    modport master (
        output mode, flush, clr_status, wen, wdata, ren,
        input  rdata, valid, full, almost_full, almost_empty, count,
               overflow, underflow, drop_count
    );

    modport slave (
        input  mode, flush, clr_status, wen, wdata, ren,
        output rdata, valid, full, almost_full, almost_empty, count,
               overflow, underflow, drop_count
    );

endinterface

// File: rtl/coax_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module coax_fifo_ram #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/coax_fifo.sv
// Parametrised first-word-fall-through FIFO with thresholds, sticky status,
// saturating drop counter, flush and runtime drop-new/drop-old policy.
module coax_fifo
    import coax_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned AF_LEVEL = 24,
    parameter int unsigned AE_LEVEL = 4
) (
    input  logic        clk,
    input  logic        reset,
    coax_fifo_if.slave  bus
);

    localparam int unsigned CW    = cnt_w(ADDR_W);
    localparam int unsigned DEPTH = 2**ADDR_W;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [CW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_rd_ptr;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic [CW-1:0]    w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_unf;
    logic             w_we;
    logic             w_drop_ev;
    logic             w_unf_ev;
    logic [WIDTH-1:0] w_rdata;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == DEPTH_C);

    // Overwrite-oldest is a simultaneous push and pop, which keeps count at DEPTH.
    always_comb begin
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_drop = 1'b0;
        w_unf  = 1'b0;
        if (w_empty) begin
            w_push = bus.wen;
            w_unf  = bus.ren;
        end else if (w_full && bus.wen && !bus.ren) begin
            w_drop = 1'b1;
            if (mode_e'(bus.mode) == MODE_DROP_OLD) begin
                w_push = 1'b1;
                w_pop  = 1'b1;
            end
        end else begin
            w_push = bus.wen;
            w_pop  = bus.ren;
        end
    end

    assign w_we      = w_push && !bus.flush && !reset;
    assign w_drop_ev = w_drop && !bus.flush;
    assign w_unf_ev  = w_unf  && !bus.flush;

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + CW'(w_push);
            r_rd_ptr <= r_rd_ptr + CW'(w_pop);
        end
    end

    // A same-cycle event takes precedence over clr_status.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_drop_cnt  <= '0;
        end else if (bus.clr_status) begin
            r_overflow  <= w_drop_ev;
            r_underflow <= w_unf_ev;
            r_drop_cnt  <= DROP_CNT_W'(w_drop_ev);
        end else begin
            r_overflow  <= r_overflow  | w_drop_ev;
            r_underflow <= r_underflow | w_unf_ev;
            if (w_drop_ev && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    coax_fifo_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (bus.wdata),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    assign bus.rdata        = w_rdata;
    assign bus.valid        = !w_empty;
    assign bus.full         = w_full;
    assign bus.almost_full  = (w_count >= AF_C);
    assign bus.almost_empty = (w_count <= AE_C);
    assign bus.count        = w_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
    assign bus.drop_count   = r_drop_cnt;

endmodule
